// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin find-first arbiter.
// Scan direction constants, FSM state type and modulo-N index stepping.
package arb_pkg;

  localparam int ARB_DIR_UP = 0;
  localparam int ARB_DIR_DN = 1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  function automatic int unsigned wrap_inc(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic int unsigned wrap_dec(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/ff_rotate_scan.sv
// Rotated find-first scan: first set bit of vec starting at start,
// walking up (DIR=0) or down (DIR=1) with wrap at N_REQ-1 <-> 0.
module ff_rotate_scan
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIR   = ARB_DIR_UP,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;

  // rot[k] is the k-th candidate in scan order from start
  always_comb begin
    rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int p;
      logic [IDX_W-1:0] pi;
      if (DIR == ARB_DIR_DN)
        p = (int'(start) - k + N_REQ) % N_REQ;
      else
        p = (int'(start) + k) % N_REQ;
      pi = IDX_W'(p);
      rot[k] = vec[pi];
    end
  end

  always_comb begin
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int p;
      logic [IDX_W-1:0] pi;
      if (DIR == ARB_DIR_DN)
        p = (int'(start) - k + N_REQ) % N_REQ;
      else
        p = (int'(start) + k) % N_REQ;
      pi = IDX_W'(p);
      if (!found && rot[k]) begin
        found      = 1'b1;
        idx        = pi;
        onehot[pi] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_find_first_arb.sv
// Round-robin arbiter with grant hold until done or request drop.
// Define RR_ARB_PRIO_EN to add the hp_req high-priority qualifier.
module rr_find_first_arb
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIR   = ARB_DIR_UP,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
`ifdef RR_ARB_PRIO_EN
  input  logic [N_REQ-1:0] hp_req,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic             rel;
  logic [IDX_W-1:0] rel_ptr;
  logic [IDX_W-1:0] scan_start;
  logic [N_REQ-1:0] scan_vec;
  logic             win_found;
  logic [N_REQ-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    rel = done | ~req[gnt_idx_q];
    if (DIR == ARB_DIR_DN)
      rel_ptr = IDX_W'(wrap_dec(32'(gnt_idx_q), N_REQ));
    else
      rel_ptr = IDX_W'(wrap_inc(32'(gnt_idx_q), N_REQ));
    // the releasing owner sits out the same-edge re-arbitration
    if (state_q == ARB_IDLE) begin
      scan_vec   = req;
      scan_start = ptr_q;
    end else begin
      scan_vec   = req & ~gnt_q;
      scan_start = rel_ptr;
    end
  end

`ifdef RR_ARB_PRIO_EN
  logic [N_REQ-1:0] hp_vec;
  logic             hp_found, lp_found;
  logic [N_REQ-1:0] hp_onehot, lp_onehot;
  logic [IDX_W-1:0] hp_idx, lp_idx;

  assign hp_vec = scan_vec & hp_req;

  ff_rotate_scan #(.N_REQ(N_REQ), .DIR(DIR), .IDX_W(IDX_W)) u_hp_scan (
    .vec   (hp_vec),
    .start (scan_start),
    .found (hp_found),
    .onehot(hp_onehot),
    .idx   (hp_idx)
  );

  ff_rotate_scan #(.N_REQ(N_REQ), .DIR(DIR), .IDX_W(IDX_W)) u_lp_scan (
    .vec   (scan_vec),
    .start (scan_start),
    .found (lp_found),
    .onehot(lp_onehot),
    .idx   (lp_idx)
  );

  assign win_found  = hp_found ? hp_found  : lp_found;
  assign win_onehot = hp_found ? hp_onehot : lp_onehot;
  assign win_idx    = hp_found ? hp_idx    : lp_idx;
`else
  ff_rotate_scan #(.N_REQ(N_REQ), .DIR(DIR), .IDX_W(IDX_W)) u_scan (
    .vec   (scan_vec),
    .start (scan_start),
    .found (win_found),
    .onehot(win_onehot),
    .idx   (win_idx)
  );
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_found) begin
          state_d     = ARB_BUSY;
          gnt_d       = win_onehot;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (rel) begin
          ptr_d = rel_ptr;
          if (win_found) begin
            gnt_d     = win_onehot;
            gnt_idx_d = win_idx;
          end else begin
            state_d     = ARB_IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_find_first_arb.sv
// Directed bench for rr_find_first_arb: three configurations
// (N=4 up, N=5 up, N=4 down); RR_ARB_PRIO_EN adds the priority case.
module tb_rr_find_first_arb;
  import arb_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] req0, hp0;
  logic       done0;
  logic [3:0] gnt0;
  logic       gv0;
  logic [1:0] gi0;
  logic [4:0] req1;
  logic       done1;
  logic [4:0] gnt1;
  logic       gv1;
  logic [2:0] gi1;
  logic [3:0] req2;
  logic       done2;
  logic [3:0] gnt2;
  logic       gv2;
  logic [1:0] gi2;

  int checks = 0;
  int errors = 0;

  rr_find_first_arb #(.N_REQ(4), .DIR(0)) u0 (
    .clk      (clk),
    .reset    (reset),
    .req      (req0),
    .done     (done0),
`ifdef RR_ARB_PRIO_EN
    .hp_req   (hp0),
`endif
    .gnt      (gnt0),
    .gnt_valid(gv0),
    .gnt_idx  (gi0)
  );

  rr_find_first_arb #(.N_REQ(5), .DIR(0)) u1 (
    .clk      (clk),
    .reset    (reset),
    .req      (req1),
    .done     (done1),
`ifdef RR_ARB_PRIO_EN
    .hp_req   (5'b0),
`endif
    .gnt      (gnt1),
    .gnt_valid(gv1),
    .gnt_idx  (gi1)
  );

  rr_find_first_arb #(.N_REQ(4), .DIR(1)) u2 (
    .clk      (clk),
    .reset    (reset),
    .req      (req2),
    .done     (done2),
`ifdef RR_ARB_PRIO_EN
    .hp_req   (4'b0),
`endif
    .gnt      (gnt2),
    .gnt_valid(gv2),
    .gnt_idx  (gi2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0 = '0; hp0 = '0; done0 = 1'b0;
    req1 = '0; done1 = 1'b0;
    req2 = '0; done2 = 1'b0;
    #3;
    check("rst_gnt", 32'(gnt0), 32'h0);
    check("rst_gv", 32'(gv0), 32'h0);
    check("rst_gi", 32'(gi0), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // fairness
    req0 = 4'b1111;
    tick();
    check("fair_g0", 32'(gnt0), 32'b0001);
    check("fair_gv", 32'(gv0), 32'h1);
    done0 = 1'b1;
    tick();
    check("fair_g1", 32'(gnt0), 32'b0010);
    check("fair_i1", 32'(gi0), 32'd1);
    tick();
    check("fair_g2", 32'(gnt0), 32'b0100);
    tick();
    check("fair_g3", 32'(gnt0), 32'b1000);
    check("fair_i3", 32'(gi0), 32'd3);
    tick();
    check("fair_g4", 32'(gnt0), 32'b0001);
    check("fair_ptr", 32'(u0.ptr_q), 32'd0);
    done0 = 1'b0;
    tick();
    check("hold_g", 32'(gnt0), 32'b0001);

    // abandon
    req0 = 4'b0100;
    tick();
    check("ab_g", 32'(gnt0), 32'b0100);
    check("ab_ptr1", 32'(u0.ptr_q), 32'd1);
    req0 = 4'b0000;
    tick();
    check("ab_gnt", 32'(gnt0), 32'h0);
    check("ab_gv", 32'(gv0), 32'h0);
    check("ab_gi", 32'(gi0), 32'h0);
    check("ab_st", 32'(u0.state_q), 32'(ARB_IDLE));
    check("ab_ptr", 32'(u0.ptr_q), 32'd3);
    done0 = 1'b1;
    tick();
    check("idle_done_g", 32'(gnt0), 32'h0);
    check("idle_done_ptr", 32'(u0.ptr_q), 32'd3);
    done0 = 1'b0;
    req0 = 4'b1111;
    tick();
    check("ptr3_g", 32'(gnt0), 32'b1000);
    check("ptr3_i", 32'(gi0), 32'd3);

    // async reset mid-busy
    req0 = 4'b0010;
    tick();
    check("ar_pre", 32'(gnt0), 32'b0010);
    #2;
    reset = 1'b1;
    #1;
    check("ar_gnt", 32'(gnt0), 32'h0);
    check("ar_gv", 32'(gv0), 32'h0);
    check("ar_gi", 32'(gi0), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req0 = 4'b1111;
    tick();
    check("ar_first", 32'(gnt0), 32'b0001);
    req0 = 4'b0000;
    tick();
    check("ar_idle", 32'(gv0), 32'h0);

    // wrap, N=5
    req1 = 5'b10001;
    tick();
    check("w_g0", 32'(gnt1), 32'b00001);
    done1 = 1'b1;
    tick();
    check("w_g4", 32'(gnt1), 32'b10000);
    check("w_ptr1", 32'(u1.ptr_q), 32'd1);
    tick();
    check("w_wrap_g", 32'(gnt1), 32'b00001);
    check("w_wrap_ptr", 32'(u1.ptr_q), 32'd0);
    done1 = 1'b0;
    req1 = 5'b01000;
    tick();
    check("w_g3", 32'(gnt1), 32'b01000);
    req1 = 5'b11000;
    done1 = 1'b1;
    tick();
    check("w_ptr4", 32'(u1.ptr_q), 32'd4);
    check("w_g4b", 32'(gnt1), 32'b10000);
    check("w_i4", 32'(gi1), 32'd4);
    tick();
    check("w_ptr0", 32'(u1.ptr_q), 32'd0);
    check("w_i3", 32'(gi1), 32'd3);
    done1 = 1'b0;
    req1 = '0;
    tick();
    check("w_idle", 32'(gv1), 32'h0);

    // descending scan
    req2 = 4'b1011;
    tick();
    check("dn_i0", 32'(gi2), 32'd0);
    done2 = 1'b1;
    tick();
    check("dn_i3", 32'(gi2), 32'd3);
    check("dn_g3", 32'(gnt2), 32'b1000);
    tick();
    check("dn_i1", 32'(gi2), 32'd1);
    tick();
    check("dn_i0b", 32'(gi2), 32'd0);
    check("dn_ptr", 32'(u2.ptr_q), 32'd0);
    done2 = 1'b0;
    req2 = '0;
    tick();
    check("dn_idle", 32'(gv2), 32'h0);

`ifdef RR_ARB_PRIO_EN
    reset = 1'b1;
    #2;
    @(negedge clk);
    reset = 1'b0;
    req0 = 4'b1111;
    hp0 = 4'b1000;
    tick();
    check("hp_g", 32'(gnt0), 32'b1000);
    done0 = 1'b1;
    tick();
    check("hp_rel_g", 32'(gnt0), 32'b0001);
    done0 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
